if_fetch_buf: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Accepts the fetch

---
 rtl/if_fetch_buf.sv | 118 +++++++++++
 tb/tb_if_fetch_buf.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: issues one req/gnt/rvalid memory transaction at a time
// and queues {pc, instruction} pairs in a small FIFO for the decode stage.
module if_fetch_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push;
    logic              pop;

    // Accepting only while IDLE with a free slot reserves space for the one in-flight fetch.
    assign pc_ready   = (state == IDLE) && pc_valid && (count < CNT_W'(DEPTH)) && !flush;
    assign push       = (state == WAIT) && imem_rvalid && !flush;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_ready) begin
                        imem_addr <= pc_addr;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        imem_req <= 1'b0;
                        state    <= imem_gnt ? DROP : IDLE;
                    end else if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= imem_addr;
                data_mem[wr_ptr] <= imem_rdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_buf.sv
// Self-checking bench for if_fetch_buf: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_if_fetch_buf;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // Reference model: delivered instructions as a queue, plus the single outstanding fetch
    // described as "no fetch", "address phase" or "data phase" (live or cancelled).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_phase = 0;  // 0 none, 1 waiting for grant, 2 waiting for data
    bit          m_live  = 0;  // data phase result will be kept
    logic [31:0] m_addr  = '0;

    function automatic bit model_ready();
        return (m_phase == 0) && pc_valid && (q.size() < DEPTH) && !flush;
    endfunction

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_live  = 0;
    endtask

    task automatic model_update();
        ent_t e;
        bit   acc;
        bit   keep;
        bit   take;
        acc  = model_ready();
        keep = (m_phase == 2) && m_live && imem_rvalid && !flush;
        take = (q.size() != 0) && inst_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (take) begin
                e = q.pop_front();
                $display("retire pc=%08h data=%08h", e.pc, e.data);
            end
            if (keep) q.push_back({m_addr, imem_rdata});
        end
        case (m_phase)
            0: if (acc) begin
                m_phase = 1;
                m_addr  = pc_addr;
            end
            1: if (imem_gnt) begin
                m_phase = 2;
                m_live  = !flush;
            end else if (flush) begin
                m_phase = 0;
            end
            default: if (imem_rvalid) begin
                m_phase = 0;
            end else if (flush) begin
                m_live = 0;
            end
        endcase
    endtask

    task automatic advance();
        if (!rst_n) model_reset();
        else model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_valid = 0; pc_addr = '0; flush = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
    endtask

    // Zero-wait fetch: accept, grant, data; leaves the pair in the FIFO.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        pc_valid = 1; pc_addr = a; imem_gnt = 1; imem_rvalid = 0;
        advance();
        pc_valid = 0;
        advance();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = d;
        advance();
        imem_rvalid = 0;
    endtask

    task automatic drain();
        pc_valid = 0; inst_ready = 1;
        repeat (DEPTH) advance();
        inst_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
        n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h want=0", inst_data); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h want=0", inst_pc); end
        rst_n = 1;
        model_reset();
        $display("reset checked");
    endtask

    task automatic test_first_fetch();
        pc_valid = 1; pc_addr = 32'h0; imem_gnt = 1;
        #1;
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL t1_accept got=%b want=1", pc_ready); end
        advance();
        pc_valid = 0;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL t1_req got=%b want=1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL t1_addr got=%h want=0", imem_addr); end
        advance();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL t1_req_drop got=%b want=0", imem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid got=%b want=0", inst_valid); end
        advance();
        imem_rvalid = 0;
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got=%b want=1", inst_valid); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL t1_pc got=%h want=0", inst_pc); end
        n_cmp++; if (inst_data !== 32'h0000_0013) begin n_err++; $display("FAIL t1_data got=%h want=00000013", inst_data); end
        drain();
        $display("first fetch checked");
    endtask

    task automatic test_backpressure();
        inst_ready = 0;
        fetch(32'h0, 32'hA000_0000);
        fetch(32'h4, 32'hA000_0004);
        pc_valid = 1; pc_addr = 32'h8;
        #1;
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL t2_full_ready got=%b want=0", pc_ready); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL t2_head got=%h want=0", inst_pc); end
        advance();
        inst_ready = 1;
        #1;
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL t2_pop_ready got=%b want=0", pc_ready); end
        advance();
        inst_ready = 0;
        #1;
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL t2_after_pop got=%b want=1", pc_ready); end
        n_cmp++; if (inst_pc !== 32'h4) begin n_err++; $display("FAIL t2_head2 got=%h want=4", inst_pc); end
        advance();
        pc_valid = 0; imem_gnt = 1;
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL t2_addr got=%h want=8", imem_addr); end
        advance();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA000_0008;
        advance();
        imem_rvalid = 0;
        inst_ready = 1;
        advance();
        inst_ready = 0;
        n_cmp++; if (inst_pc !== 32'h8 || inst_data !== 32'hA000_0008) begin
            n_err++; $display("FAIL t2_third got=%h/%h want=00000008/a0000008", inst_pc, inst_data);
        end
        drain();
        $display("backpressure checked");
    endtask

    task automatic test_flush_wait();
        pc_valid = 1; pc_addr = 32'h40; imem_gnt = 1;
        advance();
        pc_valid = 0;
        advance();
        imem_gnt = 0; flush = 1;
        advance();
        flush = 0; pc_valid = 1; pc_addr = 32'h44;
        #1;
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL t3_drop_ready got=%b want=0", pc_ready); end
        advance();
        pc_valid = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        advance();
        imem_rvalid = 0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t3_discard got=%b want=0", inst_valid); end
        fetch(32'h100, 32'h1111_0100);
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h1111_0100) begin
            n_err++; $display("FAIL t3_next got=%b/%h/%h want=1/00000100/11110100", inst_valid, inst_pc, inst_data);
        end
        drain();
        $display("flush in wait checked");
    endtask

    task automatic test_flush_edges();
        pc_valid = 1; pc_addr = 32'h300; imem_gnt = 1;
        advance();
        pc_valid = 0; flush = 1;
        advance();
        flush = 0; imem_gnt = 0; pc_valid = 1; pc_addr = 32'h304;
        #1;
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL t4_gnt_flush_ready got=%b want=0", pc_ready); end
        imem_rvalid = 1; imem_rdata = 32'h5555_5555;
        advance();
        imem_rvalid = 0;
        #1;
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL t4_back_idle got=%b want=1", pc_ready); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t4_gnt_discard got=%b want=0", inst_valid); end
        imem_gnt = 1;
        advance();
        pc_valid = 0;
        advance();
        imem_gnt = 0; imem_rvalid = 1; flush = 1; imem_rdata = 32'h6666_6666;
        advance();
        imem_rvalid = 0; flush = 0; pc_valid = 1; pc_addr = 32'h308;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t4_rvalid_discard got=%b want=0", inst_valid); end
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL t4_rvalid_idle got=%b want=1", pc_ready); end
        pc_valid = 0;
        $display("flush edges checked");
    endtask

    task automatic test_push_pop();
        fetch(32'h200, 32'hB000_0200);
        pc_valid = 1; pc_addr = 32'h204; imem_gnt = 1;
        advance();
        pc_valid = 0;
        advance();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hB000_0204; inst_ready = 1;
        n_cmp++; if (inst_pc !== 32'h200) begin n_err++; $display("FAIL t5_head got=%h want=00000200", inst_pc); end
        advance();
        imem_rvalid = 0; inst_ready = 0;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h204 || inst_data !== 32'hB000_0204) begin
            n_err++; $display("FAIL t5_next got=%b/%h/%h want=1/00000204/b0000204", inst_valid, inst_pc, inst_data);
        end
        inst_ready = 1;
        advance();
        inst_ready = 0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t5_empty got=%b want=0", inst_valid); end
        $display("push/pop checked");
    endtask

    task automatic test_async_reset();
        fetch(32'h400, 32'hC000_0400);
        pc_valid = 1; pc_addr = 32'h404; imem_gnt = 1;
        advance();
        pc_valid = 0;
        advance();
        imem_gnt = 0;
        rst_n = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL t6_req got=%b want=0", imem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t6_valid got=%b want=0", inst_valid); end
        n_cmp++; if (inst_pc !== 32'h0 || inst_data !== 32'h0 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL t6_regs got=%h/%h/%h want=0/0/0", inst_pc, inst_data, imem_addr);
        end
        advance();
        rst_n = 1;
        imem_rvalid = 1; imem_rdata = 32'h7777_7777;
        advance();
        imem_rvalid = 0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL t6_stale_rvalid got=%b want=0", inst_valid); end
        $display("async reset checked");
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            pc_valid    = ($urandom_range(3) != 0);
            pc_addr     = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            flush       = ($urandom_range(11) == 0);
            imem_gnt    = $urandom_range(1);
            imem_rvalid = $urandom_range(1);
            imem_rdata  = $urandom;
            inst_ready  = ($urandom_range(2) != 0);
            #1;
            n_cmp++; if (pc_ready !== model_ready()) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, pc_ready, model_ready()); end
            n_cmp++; if (imem_req !== (m_phase == 1)) begin n_err++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", c, imem_req, m_phase == 1); end
            if (m_phase != 0) begin
                n_cmp++; if (imem_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", c, imem_addr, m_addr); end
            end
            n_cmp++; if (inst_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, inst_valid, q.size() != 0); end
            if (q.size() != 0) begin
                n_cmp++; if (inst_pc !== q[0].pc || inst_data !== q[0].data) begin
                    n_err++; $display("FAIL rnd_head cyc=%0d got=%h/%h want=%h/%h", c, inst_pc, inst_data, q[0].pc, q[0].data);
                end
            end
            advance();
        end
        idle_inputs();
        $display("random traffic checked");
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_flush_wait();
        test_flush_edges();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
